// File: rtl/slot_reel_controller.sv
// N-reel slot machine controller: button sync/edge detect, reel counters,
// staggered reel stops, win evaluation and a saturating win tally.
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous active-low reset
//   start_stop - raw button level (asynchronous)
//   state      - FSM state code (SET=0 RUN=1 STOPPING=2 EVAL=3 WIN=4 LOSE=5)
//   reels      - packed reel symbols, reel i at [i*SYM_W +: SYM_W]
//   spinning   - bit i set while reel i advances
//   win        - high while in WIN
//   win_count  - saturating number of wins
module slot_reel_controller #(
    parameter int N_REELS   = 3,
    parameter int N_SYMBOLS = 8,
    parameter int SYM_W     = $clog2(N_SYMBOLS),
    parameter int STOP_GAP  = 4,
    parameter int CNT_W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_stop,
    output logic [2:0]                 state,
    output logic [N_REELS*SYM_W-1:0]   reels,
    output logic [N_REELS-1:0]         spinning,
    output logic                       win,
    output logic [CNT_W-1:0]           win_count
);

    localparam int GAP_W = $clog2(N_REELS * STOP_GAP + 1);

    typedef enum logic [2:0] {
        S_SET      = 3'd0,
        S_RUN      = 3'd1,
        S_STOPPING = 3'd2,
        S_EVAL     = 3'd3,
        S_WIN      = 3'd4,
        S_LOSE     = 3'd5
    } state_t;

    state_t                     st_q, st_d;
    logic                       s0, s1, s2;
    logic                       press;
    logic [GAP_W-1:0]           gap_q, gap_d;
    logic [N_REELS-1:0]         spin_d;
    logic [N_REELS-1:0]         stop_now;
    logic [N_REELS*SYM_W-1:0]   reels_d;
    logic [CNT_W-1:0]           cnt_d;
    logic                       all_eq;

    assign press = s1 & ~s2;
    assign state = st_q;

    // Reel i steps by (i+1) with a single conditional subtract for the wrap,
    // and holds on its own stop edge.
    for (genvar g = 0; g < N_REELS; g++) begin : g_reel
        logic [SYM_W:0] sum;
        logic [SYM_W-1:0] nxt;

        assign sum = {1'b0, reels[g*SYM_W +: SYM_W]} + (SYM_W+1)'(g + 1);
        assign nxt = (sum >= (SYM_W+1)'(N_SYMBOLS))
                   ? SYM_W'(sum - (SYM_W+1)'(N_SYMBOLS))
                   : SYM_W'(sum);

        if (g == 0) begin : g_first
            assign stop_now[g] = (st_q == S_RUN) && press;
        end else begin : g_rest
            // gap counter reads k-1 on the k-th edge after reel 0 stopped
            assign stop_now[g] = (st_q == S_STOPPING)
                              && (int'(gap_q) == g * STOP_GAP - 1);
        end

        assign reels_d[g*SYM_W +: SYM_W] = (spinning[g] && !stop_now[g])
                                         ? nxt
                                         : reels[g*SYM_W +: SYM_W];
    end

    always_comb begin
        all_eq = 1'b1;
        for (int i = 1; i < N_REELS; i++) begin
            if (reels[i*SYM_W +: SYM_W] != reels[0 +: SYM_W]) begin
                all_eq = 1'b0;
            end
        end
    end

    always_comb begin
        st_d   = st_q;
        spin_d = spinning;
        gap_d  = gap_q;
        cnt_d  = win_count;
        unique case (st_q)
            S_SET: begin
                if (press) begin
                    st_d   = S_RUN;
                    spin_d = '1;
                end
            end
            S_RUN: begin
                if (press) begin
                    st_d      = S_STOPPING;
                    spin_d[0] = 1'b0;
                    gap_d     = '0;
                end
            end
            S_STOPPING: begin
                gap_d  = gap_q + 1'b1;
                spin_d = spinning & ~stop_now;
                if (spinning == '0) begin
                    st_d = S_EVAL;
                end
            end
            S_EVAL: begin
                if (all_eq) begin
                    st_d = S_WIN;
                    if (win_count != '1) begin
                        cnt_d = win_count + 1'b1;
                    end
                end else begin
                    st_d = S_LOSE;
                end
            end
            S_WIN, S_LOSE: begin
                if (press) begin
                    st_d   = S_RUN;
                    spin_d = '1;
                end
            end
            default: begin
                st_d = S_SET;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            st_q      <= S_SET;
            s0        <= 1'b0;
            s1        <= 1'b0;
            s2        <= 1'b0;
            gap_q     <= '0;
            reels     <= '0;
            spinning  <= '0;
            win       <= 1'b0;
            win_count <= '0;
        end else begin
            st_q      <= st_d;
            s0        <= start_stop;
            s1        <= s0;
            s2        <= s1;
            gap_q     <= gap_d;
            reels     <= reels_d;
            spinning  <= spin_d;
            win       <= (st_d == S_WIN);
            win_count <= cnt_d;
        end
    end

endmodule

// File: tb/tb_slot_reel_controller.sv
// Testbench for slot_reel_controller: three configurations driven in
// parallel and checked every cycle against an arithmetic reference model.
module tb_slot_reel_controller;

    localparam int NR = 3;
    localparam int SG = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start_stop = 1'b0;

    always #5 clk = ~clk;

    logic [2:0] st0, st1, st2;
    logic [8:0] rl0, rl1, rl2;
    logic [2:0] sp0, sp1, sp2;
    logic       w0, w1, w2;
    logic [7:0] wc0, wc2;
    logic [1:0] wc1;

    slot_reel_controller dut0 (
        .clk(clk), .rst(rst), .start_stop(start_stop),
        .state(st0), .reels(rl0), .spinning(sp0),
        .win(w0), .win_count(wc0)
    );

    slot_reel_controller #(.CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .start_stop(start_stop),
        .state(st1), .reels(rl1), .spinning(sp1),
        .win(w1), .win_count(wc1)
    );

    slot_reel_controller #(.N_SYMBOLS(5)) dut2 (
        .clk(clk), .rst(rst), .start_stop(start_stop),
        .state(st2), .reels(rl2), .spinning(sp2),
        .win(w2), .win_count(wc2)
    );

    int n_checks = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Model: phase code, edges since reel 0 stopped, win tally, and
    // total advance count per reel (symbol = (i+1)*count mod N).
    int ns[3] = '{8, 8, 5};
    int cmax[3] = '{255, 3, 255};
    int ms[3];
    int ts[3];
    int cnt[3];
    int adv[3][NR];
    bit hist[3];

    function automatic int reel_val(int c, int i);
        return ((i + 1) * adv[c][i]) % ns[c];
    endfunction

    function automatic logic [8:0] exp_reels(int c);
        logic [8:0] r;
        r = '0;
        for (int i = 0; i < NR; i++) r[i*3 +: 3] = 3'(reel_val(c, i));
        return r;
    endfunction

    function automatic logic [2:0] exp_spin(int c);
        logic [2:0] s;
        s = '0;
        if (ms[c] == 1) s = '1;
        else if (ms[c] == 2)
            for (int i = 1; i < NR; i++) s[i] = (ts[c] < i * SG);
        return s;
    endfunction

    task automatic model_step();
        bit p;
        bit eq;
        if (!rst) begin
            for (int c = 0; c < 3; c++) begin
                ms[c] = 0;
                ts[c] = 0;
                cnt[c] = 0;
                for (int i = 0; i < NR; i++) adv[c][i] = 0;
            end
            hist = '{0, 0, 0};
        end else begin
            // hist[k] = button sample k+1 edges ago
            p = hist[1] && !hist[2];
            for (int c = 0; c < 3; c++) begin
                case (ms[c])
                    0: if (p) ms[c] = 1;
                    1: begin
                        if (p) begin
                            ms[c] = 2;
                            ts[c] = 0;
                            for (int i = 1; i < NR; i++) adv[c][i]++;
                        end else begin
                            for (int i = 0; i < NR; i++) adv[c][i]++;
                        end
                    end
                    2: begin
                        ts[c]++;
                        if (ts[c] == (NR - 1) * SG + 1) ms[c] = 3;
                        else
                            for (int i = 1; i < NR; i++)
                                if (ts[c] < i * SG) adv[c][i]++;
                    end
                    3: begin
                        eq = 1'b1;
                        for (int i = 1; i < NR; i++)
                            if (reel_val(c, i) != reel_val(c, 0)) eq = 1'b0;
                        if (eq) begin
                            ms[c] = 4;
                            if (cnt[c] < cmax[c]) cnt[c]++;
                        end else begin
                            ms[c] = 5;
                        end
                    end
                    default: if (p) ms[c] = 1;
                endcase
            end
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = start_stop;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cmp_cfg(int c, logic [2:0] st, logic [8:0] rl,
                           logic [2:0] sp, logic w, logic [7:0] wc);
        check($sformatf("cfg%0d state @%0t", c, $time), 32'(st), ms[c]);
        check($sformatf("cfg%0d reels @%0t", c, $time), 32'(rl),
              32'(exp_reels(c)));
        check($sformatf("cfg%0d spinning @%0t", c, $time), 32'(sp),
              32'(exp_spin(c)));
        check($sformatf("cfg%0d win @%0t", c, $time), 32'(w),
              32'(ms[c] == 4));
        check($sformatf("cfg%0d win_count @%0t", c, $time), 32'(wc), cnt[c]);
    endtask

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            cmp_cfg(0, st0, rl0, sp0, w0, wc0);
            cmp_cfg(1, st1, rl1, sp1, w1, {6'd0, wc1});
            cmp_cfg(2, st2, rl2, sp2, w2, wc2);
        end
    end

    // Called at a negedge; returns at the negedge after the FSM acted.
    task automatic do_press();
        start_stop = 1'b1;
        @(negedge clk);
        start_stop = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic run_round(int t, bit lit, bit extra);
        do_press();
        for (int j = 1; j <= t - 2; j++) begin
            @(negedge clk);
            if (lit && j == 2) check("n5 reel1 before wrap", 32'(rl2[5:3]), 4);
            if (lit && j == 3) check("n5 reel1 wrap", 32'(rl2[5:3]), 1);
            if (lit && j == 5) begin
                check("five advances reels", 32'(rl0), {23'd0, 3'd7, 3'd2, 3'd5});
                check("five advances spinning", 32'(sp0), 3'b111);
            end
        end
        do_press();
        if (lit) begin
            check("stop edge spinning", 32'(sp0), 3'b110);
            check("stop edge state", 32'(st0), 2);
        end
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            if (extra && j == 1) start_stop = 1'b1;
            if (extra && j == 2) start_stop = 1'b0;
            if (lit && j == 4) check("reel1 stop spinning", 32'(sp0), 3'b100);
            if (lit && j == 8) begin
                check("reel2 stop spinning", 32'(sp0), 0);
                check("last stop state", 32'(st0), 2);
            end
            if (lit && j == 9) check("eval state", 32'(st0), 3);
            if (lit && j == 10) begin
                check("win state", 32'(st0), 4);
                check("win flag", 32'(w0), 1);
                check("win reels", 32'(rl0), 0);
            end
        end
    endtask

    int wc_exp[5] = '{1, 2, 3, 3, 3};

    initial begin
        chk_en = 1'b1;
        rst = 1'b0;
        start_stop = 1'b1;
        repeat (3) @(negedge clk);
        check("reset state", 32'(st0), 0);
        check("reset reels", 32'(rl0), 0);
        check("reset spinning", 32'(sp0), 0);
        check("reset win", 32'(w0), 0);
        check("reset win_count", 32'(wc0), 0);

        rst = 1'b1;
        @(negedge clk);
        check("held press +1", 32'(st0), 0);
        @(negedge clk);
        check("held press +2", 32'(st0), 0);
        @(negedge clk);
        check("held press run", 32'(st0), 1);
        repeat (6) @(negedge clk);
        check("held press single", 32'(st0), 1);
        start_stop = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rerun reset reels", 32'(rl0), 0);
        rst = 1'b1;

        for (int r = 0; r < 5; r++) begin
            run_round(8, r == 0, r == 0);
            check($sformatf("sat count round %0d", r + 1), 32'(wc1), wc_exp[r]);
        end
        check("five wins count", 32'(wc0), 5);

        run_round(9, 1'b0, 1'b0);
        check("lose reels", 32'(rl0), {23'd0, 3'd3, 3'd2, 3'd1});
        check("lose state", 32'(st0), 5);
        check("lose win", 32'(w0), 0);
        check("lose count", 32'(wc0), 5);

        do_press();
        repeat (3) @(negedge clk);
        do_press();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort state", 32'(st0), 0);
        check("abort reels", 32'(rl0), 0);
        check("abort spinning", 32'(sp0), 0);
        rst = 1'b1;

        repeat (3000) begin
            @(negedge clk);
            rst = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 15) == 0) start_stop = ~start_stop;
        end
        rst = 1'b1;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
